// File: rtl/periph_dma_pkg.sv
// Shared types and constants for the peripheral word-copy DMA engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package periph_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE,
        ST_ERR
    } dma_state_t;

    // Byte stride between consecutive words on the memory bus.
    localparam int WORD_BYTES = 4;

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Cycles without bus progress before a transfer is aborted.
    localparam int DEFAULT_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/periph_dma_watchdog.sv
// Bus-progress watchdog: down-counter that expires after TIMEOUT_CYC-1 stalled cycles.
// Latency: expire is combinational from the count, asserted in the cycle the count hits zero.
// Backpressure: none; clear has priority over enable and masks expire.
module periph_dma_watchdog
    import periph_dma_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk_periph_100mhz,
    input  logic rst_periph_domain_n_sync,
    input  logic wd_clear,
    input  logic wd_enable,
    output logic wd_expire
);

    localparam int CNT_BITS = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_BITS-1:0] LOAD_VAL = CNT_BITS'(TIMEOUT_CYC - 1);

    logic [CNT_BITS-1:0] wd_cnt;

    // Reload on clear, otherwise count down while enabled and stop at zero.
    always_ff @(posedge clk_periph_100mhz or negedge rst_periph_domain_n_sync) begin
        if (!rst_periph_domain_n_sync) begin
            wd_cnt <= LOAD_VAL;
        end else if (wd_clear) begin
            wd_cnt <= LOAD_VAL;
        end else if (wd_enable && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - CNT_BITS'(1);
        end
    end

    assign wd_expire = wd_enable & ~wd_clear & (wd_cnt == '0);

endmodule

// File: rtl/periph_dma_engine.sv
// Word-copy DMA: read-then-write per word over a single-master bus, done/error pulse at the end.
// Latency: first mem_req one cycle after the start edge is sampled; 4 cycles/word best case.
// Backpressure: mem_req held until mem_gnt; waits on mem_rvalid; watchdog aborts a stalled bus.
module periph_dma_engine
    import periph_dma_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk_periph_100mhz,
    input  logic              rst_periph_domain_n_sync,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              cfg_start,
    output logic              xfer_busy,
    output logic              xfer_done,
    output logic              xfer_error,
    output logic [CNT_W-1:0]  xfer_words_left,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    dma_state_t        state;
    logic              cfg_start_q;
    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;

    logic start_pulse;
    logic misaligned;
    logic in_req;
    logic in_wait;
    logic bus_progress;
    logic wd_expire;

    assign start_pulse  = cfg_start & ~cfg_start_q;
    assign misaligned   = ((cfg_src_addr[1:0] & ALIGN_MASK) != 2'b00) ||
                          ((cfg_dst_addr[1:0] & ALIGN_MASK) != 2'b00);
    assign in_req       = (state == ST_RD_REQ)  || (state == ST_WR_REQ);
    assign in_wait      = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
    // Responses are only accepted in WAIT states; a grant only counts in REQ states.
    assign bus_progress = (in_req & mem_gnt) | (in_wait & mem_rvalid);

    periph_dma_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_periph_100mhz        (clk_periph_100mhz),
        .rst_periph_domain_n_sync (rst_periph_domain_n_sync),
        .wd_clear                 (~(in_req | in_wait) | bus_progress),
        .wd_enable                (in_req | in_wait),
        .wd_expire                (wd_expire)
    );

    // Transfer FSM with registered bus and status outputs; mem_wdata doubles as the read buffer.
    always_ff @(posedge clk_periph_100mhz or negedge rst_periph_domain_n_sync) begin
        if (!rst_periph_domain_n_sync) begin
            state           <= ST_IDLE;
            cfg_start_q     <= 1'b0;
            src_cur         <= '0;
            dst_cur         <= '0;
            xfer_busy       <= 1'b0;
            xfer_done       <= 1'b0;
            xfer_error      <= 1'b0;
            xfer_words_left <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
        end else begin
            cfg_start_q <= cfg_start;
            xfer_done   <= 1'b0;
            xfer_error  <= 1'b0;
            if (wd_expire) begin
                state      <= ST_ERR;
                xfer_error <= 1'b1;
                mem_req    <= 1'b0;
                mem_we     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_pulse) begin
                            src_cur         <= cfg_src_addr;
                            dst_cur         <= cfg_dst_addr;
                            xfer_words_left <= cfg_count;
                            xfer_busy       <= 1'b1;
                            if (misaligned) begin
                                state      <= ST_ERR;
                                xfer_error <= 1'b1;
                            end else if (cfg_count == '0) begin
                                state     <= ST_DONE;
                                xfer_done <= 1'b1;
                            end else begin
                                state    <= ST_RD_REQ;
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= cfg_src_addr;
                            end
                        end
                    end
                    ST_RD_REQ: begin
                        if (mem_gnt) begin
                            state   <= ST_RD_WAIT;
                            mem_req <= 1'b0;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (mem_rvalid) begin
                            if (mem_err) begin
                                state      <= ST_ERR;
                                xfer_error <= 1'b1;
                            end else begin
                                state     <= ST_WR_REQ;
                                mem_wdata <= mem_rdata;
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= dst_cur;
                            end
                        end
                    end
                    ST_WR_REQ: begin
                        if (mem_gnt) begin
                            state   <= ST_WR_WAIT;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                    end
                    ST_WR_WAIT: begin
                        if (mem_rvalid) begin
                            if (mem_err) begin
                                state      <= ST_ERR;
                                xfer_error <= 1'b1;
                            end else begin
                                src_cur         <= src_cur + STRIDE;
                                dst_cur         <= dst_cur + STRIDE;
                                xfer_words_left <= xfer_words_left - CNT_W'(1);
                                if (xfer_words_left == CNT_W'(1)) begin
                                    state     <= ST_DONE;
                                    xfer_done <= 1'b1;
                                end else begin
                                    state    <= ST_RD_REQ;
                                    mem_req  <= 1'b1;
                                    mem_we   <= 1'b0;
                                    mem_addr <= src_cur + STRIDE;
                                end
                            end
                        end
                    end
                    ST_DONE, ST_ERR: begin
                        state     <= ST_IDLE;
                        xfer_busy <= 1'b0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        xfer_busy <= 1'b0;
                        mem_req   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_periph_dma_engine.sv
// Scoreboard bench for periph_dma_engine with a randomized memory responder and reference copy model.
// Latency: checks throughput and watchdog timing on directed transfers, ordering on random ones.
// Backpressure: responder randomizes grant and response delays and injects stray responses.
module tb_periph_dma_engine;

    logic        clk_periph_100mhz = 1'b0;
    logic        rst_periph_domain_n_sync;
    logic [31:0] cfg_src_addr;
    logic [31:0] cfg_dst_addr;
    logic [15:0] cfg_count;
    logic        cfg_start;
    logic        xfer_busy;
    logic        xfer_done;
    logic        xfer_error;
    logic [15:0] xfer_words_left;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    periph_dma_engine #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .CNT_W       (16),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_periph_100mhz        (clk_periph_100mhz),
        .rst_periph_domain_n_sync (rst_periph_domain_n_sync),
        .cfg_src_addr             (cfg_src_addr),
        .cfg_dst_addr             (cfg_dst_addr),
        .cfg_count                (cfg_count),
        .cfg_start                (cfg_start),
        .xfer_busy                (xfer_busy),
        .xfer_done                (xfer_done),
        .xfer_error               (xfer_error),
        .xfer_words_left          (xfer_words_left),
        .mem_req                  (mem_req),
        .mem_we                   (mem_we),
        .mem_addr                 (mem_addr),
        .mem_wdata                (mem_wdata),
        .mem_gnt                  (mem_gnt),
        .mem_rvalid               (mem_rvalid),
        .mem_rdata                (mem_rdata),
        .mem_err                  (mem_err)
    );

    always #5 clk_periph_100mhz = ~clk_periph_100mhz;

    int cyc = 0;
    always @(posedge clk_periph_100mhz) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct packed {
        logic        is_err;
        logic [15:0] wl;
    } outc_t;

    txn_t        exp_txn[$];
    outc_t       exp_out[$];
    logic [31:0] bus_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    int n_checks = 0;
    int n_errors = 0;

    // responder configuration and state
    int          gnt_max = 0;
    int          rv_max = 0;
    int          err_at = -1;
    int          txn_idx = 0;
    bit          nogrant = 0;
    bit          spur_en = 0;
    bit          wr_hold = 0;
    int          gnt_wait = 0;
    int          resp_wait = 0;
    bit          resp_pending = 0;
    logic [31:0] resp_data;
    bit          resp_err;

    // per-transfer observations
    int first_req;
    int end_cyc;
    int req_cycles;
    int busy_cycles;

    function automatic logic [31:0] init_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_data(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_data(a);
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: copy word k from s+4k to d+4k in order; a failing bus access ends the job.
    task automatic model_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                              input int ea, input bit push_out);
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] data;
        if ((s[1:0] != 2'b00) || (d[1:0] != 2'b00)) begin
            if (push_out) exp_out.push_back('{is_err: 1'b1, wl: n});
            return;
        end
        for (int k = 0; k < int'(n); k++) begin
            ra   = s + 32'(4 * k);
            wa   = d + 32'(4 * k);
            data = ref_rd(ra);
            exp_txn.push_back('{we: 1'b0, addr: ra, data: data});
            if (ea == 2 * k) begin
                if (push_out) exp_out.push_back('{is_err: 1'b1, wl: n - 16'(k)});
                return;
            end
            exp_txn.push_back('{we: 1'b1, addr: wa, data: data});
            if (ea == 2 * k + 1) begin
                if (push_out) exp_out.push_back('{is_err: 1'b1, wl: n - 16'(k)});
                return;
            end
            ref_mem[wa] = data;
        end
        if (push_out) exp_out.push_back('{is_err: 1'b0, wl: 16'd0});
    endtask

    // Memory responder: grants after a random delay, answers one cycle-plus-delay later.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_err    = 1'b0;
        forever begin
            @(posedge clk_periph_100mhz);
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
            mem_rdata  = $urandom;
            if (resp_pending) begin
                if (resp_wait == 0) begin
                    mem_rvalid   = 1'b1;
                    mem_rdata    = resp_data;
                    mem_err      = resp_err;
                    resp_pending = 0;
                end else begin
                    resp_wait--;
                end
            end else if (mem_req && !nogrant && gnt_wait == 0) begin
                mem_gnt  = 1'b1;
                resp_err = (txn_idx == err_at);
                txn_idx++;
                if (mem_we) begin
                    resp_data = $urandom;
                    if (!resp_err) bus_mem[mem_addr] = mem_wdata;
                    resp_wait = wr_hold ? 8 : int'($urandom_range(rv_max, 0));
                end else begin
                    resp_data = bus_rd(mem_addr);
                    resp_wait = int'($urandom_range(rv_max, 0));
                end
                resp_pending = 1;
                gnt_wait     = int'($urandom_range(gnt_max, 0));
                if (spur_en && $urandom_range(3, 0) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_err    = 1'b1;
                end
            end else begin
                if (mem_req && gnt_wait > 0) gnt_wait--;
                if (spur_en && (mem_req || !xfer_busy) && $urandom_range(3, 0) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_err    = 1'($urandom_range(1, 0));
                end
            end
        end
    end

    // Monitor: pops expected bus transactions on grant and expected outcomes on pulses.
    initial begin
        txn_t  et;
        outc_t eo;
        forever begin
            @(negedge clk_periph_100mhz);
            if (rst_periph_domain_n_sync) begin
                if (mem_req && mem_gnt) begin
                    if (exp_txn.size() == 0) begin
                        chk(0, "unexpected_bus_txn", {31'd0, mem_we, mem_addr}, 64'd0);
                    end else begin
                        et = exp_txn.pop_front();
                        chk(mem_we == et.we && mem_addr == et.addr, "bus_txn_kind_addr",
                            {31'd0, mem_we, mem_addr}, {31'd0, et.we, et.addr});
                        if (et.we) chk(mem_wdata == et.data, "bus_wdata", {32'd0, mem_wdata}, {32'd0, et.data});
                    end
                end
                if (xfer_done || xfer_error) begin
                    chk(xfer_busy && !(xfer_done && xfer_error), "pulse_busy_exclusive",
                        {61'd0, xfer_busy, xfer_done, xfer_error}, 64'd0);
                    if (exp_out.size() == 0) begin
                        chk(0, "unexpected_pulse", {62'd0, xfer_done, xfer_error}, 64'd0);
                    end else begin
                        eo = exp_out.pop_front();
                        chk(xfer_error == eo.is_err, "outcome_kind", {63'd0, xfer_error}, {63'd0, eo.is_err});
                        chk(xfer_words_left == eo.wl, "outcome_words_left",
                            {48'd0, xfer_words_left}, {48'd0, eo.wl});
                    end
                end
            end
        end
    end

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input int ea, input int gmax, input int rvmax);
        bit got;
        bit tog;
        got     = 0;
        tog     = (n != 0) && (s[1:0] == 2'b00) && (d[1:0] == 2'b00);
        err_at  = ea;
        gnt_max = gmax;
        rv_max  = rvmax;
        txn_idx = 0;
        if (nogrant && tog) exp_out.push_back('{is_err: 1'b1, wl: n});
        else model_xfer(s, d, n, ea, 1);
        @(negedge clk_periph_100mhz);
        cfg_src_addr = s;
        cfg_dst_addr = d;
        cfg_count    = n;
        cfg_start    = 1'b1;
        first_req    = -1;
        end_cyc      = -1;
        req_cycles   = 0;
        busy_cycles  = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk_periph_100mhz);
            if (mem_req) begin
                req_cycles++;
                if (first_req < 0) first_req = cyc;
            end
            if (xfer_busy) busy_cycles++;
            if (xfer_done || xfer_error) begin
                got     = 1;
                end_cyc = cyc;
            end
            // Later cfg changes and a second rising edge mid-transfer must be ignored.
            if (i == 0) begin
                cfg_start    = 1'b0;
                cfg_src_addr = $urandom;
                cfg_dst_addr = $urandom;
                cfg_count    = 16'($urandom);
            end else if (i == 1 && tog) begin
                cfg_start = 1'b1;
            end else if (i == 2) begin
                cfg_start = 1'b0;
            end
        end
        cfg_start = 1'b0;
        if (!got) chk(0, "xfer_completion_timeout", 64'd0, 64'd1);
        @(negedge clk_periph_100mhz);
        chk(!xfer_busy && !mem_req, "idle_after_pulse", {62'd0, xfer_busy, mem_req}, 64'd0);
        chk(exp_txn.size() == 0 && exp_out.size() == 0, "scoreboard_drained",
            {32'(exp_txn.size()), 32'(exp_out.size())}, 64'd0);
        repeat ($urandom_range(2, 0)) @(negedge clk_periph_100mhz);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit          seen;
        logic [31:0] s;
        logic [31:0] d;
        logic [15:0] n;
        int          ea;

        rst_periph_domain_n_sync = 1'b0;
        cfg_src_addr = '0;
        cfg_dst_addr = '0;
        cfg_count    = '0;
        cfg_start    = 1'b0;
        repeat (3) @(negedge clk_periph_100mhz);
        chk({mem_req, mem_we, xfer_busy, xfer_done, xfer_error, xfer_words_left} == '0, "reset_ctrl_outputs",
            {43'd0, mem_req, mem_we, xfer_busy, xfer_done, xfer_error, xfer_words_left}, 64'd0);
        chk((mem_addr | mem_wdata) == '0, "reset_bus_outputs", {mem_addr, mem_wdata}, 64'd0);
        rst_periph_domain_n_sync = 1'b1;
        repeat (2) @(negedge clk_periph_100mhz);

        // three words, zero-wait bus: 4 cycles per word
        run_xfer(32'h1000, 32'h2000, 16'd3, -1, 0, 0);
        chk(end_cyc - first_req == 12, "throughput_done_latency", 64'(end_cyc - first_req), 64'd12);

        // zero-length transfer
        run_xfer(32'h1000, 32'h2000, 16'd0, -1, 0, 0);
        chk(busy_cycles == 1 && req_cycles == 0, "zero_count_busy_req",
            {32'(busy_cycles), 32'(req_cycles)}, {32'd1, 32'd0});

        // misaligned source
        run_xfer(32'h1002, 32'h2000, 16'd4, -1, 0, 0);
        chk(req_cycles == 0, "misaligned_no_bus", 64'(req_cycles), 64'd0);

        // error on the second read
        run_xfer(32'h1000, 32'h2000, 16'd2, 2, 1, 1);

        // bus never grants: watchdog abort
        nogrant = 1;
        run_xfer(32'h1000, 32'h2000, 16'd2, -1, 0, 0);
        chk(end_cyc - first_req == 16, "watchdog_abort_latency", 64'(end_cyc - first_req), 64'd16);
        nogrant = 0;

        // source address wraps to zero
        run_xfer(32'hFFFF_FFFC, 32'h3000, 16'd2, -1, 0, 1);

        // reset asserted while waiting for the write response
        wr_hold = 1;
        err_at  = -1;
        gnt_max = 0;
        rv_max  = 0;
        txn_idx = 0;
        model_xfer(32'h4000, 32'h5000, 16'd1, -1, 0);
        @(negedge clk_periph_100mhz);
        cfg_src_addr = 32'h4000;
        cfg_dst_addr = 32'h5000;
        cfg_count    = 16'd1;
        cfg_start    = 1'b1;
        @(negedge clk_periph_100mhz);
        cfg_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_periph_100mhz);
            if (mem_req && mem_gnt && mem_we) seen = 1;
        end
        chk(seen, "reset_test_write_granted", {63'd0, seen}, 64'd1);
        @(posedge clk_periph_100mhz);
        #2;
        chk(xfer_busy && !mem_req, "in_write_wait_before_reset", {62'd0, xfer_busy, mem_req}, 64'd2);
        rst_periph_domain_n_sync = 1'b0;
        #1;
        chk({mem_req, mem_we, xfer_busy, xfer_done, xfer_error, xfer_words_left} == '0, "async_reset_ctrl",
            {43'd0, mem_req, mem_we, xfer_busy, xfer_done, xfer_error, xfer_words_left}, 64'd0);
        chk((mem_addr | mem_wdata) == '0, "async_reset_bus", {mem_addr, mem_wdata}, 64'd0);
        repeat (2) @(negedge clk_periph_100mhz);
        rst_periph_domain_n_sync = 1'b1;
        wr_hold = 0;
        repeat (12) @(negedge clk_periph_100mhz);
        chk(!resp_pending && !xfer_busy && !mem_req, "late_rvalid_ignored",
            {61'd0, resp_pending, xfer_busy, mem_req}, 64'd0);
        chk(exp_txn.size() == 0 && exp_out.size() == 0, "reset_scoreboard_drained",
            {32'(exp_txn.size()), 32'(exp_out.size())}, 64'd0);

        // normal operation after reset
        run_xfer(32'h6000, 32'h7000, 16'd3, -1, 1, 1);

        // randomized transfers with overlapping windows and stray responses
        spur_en = 1;
        for (int t = 0; t < 30; t++) begin
            s = 32'h100 + 32'($urandom_range(63, 0) << 2);
            d = 32'h180 + 32'($urandom_range(63, 0) << 2);
            if ($urandom_range(7, 0) == 0) s[1:0] = 2'($urandom_range(3, 1));
            n  = 16'($urandom_range(6, 0));
            ea = -1;
            if (n != 0 && $urandom_range(4, 0) == 0) ea = int'($urandom_range(2 * int'(n) - 1, 0));
            run_xfer(s, d, n, ea, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end
        spur_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
